// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bundle carrying a control word and a data word between pipeline stages.
// The master drives valid/ctrl/data and the slave answers with ready.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 101
) ();
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer, registered ready and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add the saturating stall counter port stall_cnt_o.
module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 101
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              flush_i,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  // Bit 0 marks the main entry valid, bit 1 the skid entry valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e            state_q;
  logic [CTRL_W-1:0] mCtrl_q;
  logic [DATA_W-1:0] mData_q;
  logic [CTRL_W-1:0] sCtrl_q;
  logic [DATA_W-1:0] sData_q;
  logic              inFire;

  assign up.ready = ~state_q[1];
  assign dn.valid = state_q[0];
  assign dn.ctrl  = mCtrl_q;
  assign dn.data  = mData_q;

  assign inFire = up.valid & ~state_q[1];

  // mCtrl_q is cleared whenever the main entry empties so bubbles carry no control bits.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= EMPTY;
      mCtrl_q <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
      mCtrl_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (inFire) begin
            state_q <= ONE;
            mCtrl_q <= up.ctrl;
            mData_q <= up.data;
          end
        end
        ONE: begin
          if (inFire && dn.ready) begin
            mCtrl_q <= up.ctrl;
            mData_q <= up.data;
          end else if (inFire) begin
            state_q <= FULL;
            sCtrl_q <= up.ctrl;
            sData_q <= up.data;
          end else if (dn.ready) begin
            state_q <= EMPTY;
            mCtrl_q <= '0;
          end
        end
        FULL: begin
          if (dn.ready) begin
            state_q <= ONE;
            mCtrl_q <= sCtrl_q;
            mData_q <= sData_q;
          end
        end
        default: begin
          state_q <= EMPTY;
          mCtrl_q <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stallCnt_q;
  logic [31:0] stallCnt_d;

  // Flush does not clear the counter; only reset does.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (state_q[0] && !dn.ready && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt_o = stallCnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios with hand-computed values,
// then randomized traffic against a FIFO scoreboard.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 101;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic flush = 1'b0;

  always #5 CLK = ~CLK;

  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) upIf ();
  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dnIf ();

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stallCnt;
`endif

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .flush_i (flush),
    .up      (upIf.slave),
    .dn      (dnIf.master)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o (stallCnt)
`endif
  );

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t      modelQ[$];
  logic [31:0] modelStall = '0;
  int          checksDone = 0;
  int          checksPassed = 0;

  function automatic logic [DATA_W-1:0] mkData(input logic [7:0] c);
    return {c, ~c, 85'h0_1234_5678_9ABC_DEF0_1357};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checksDone++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, and update the FIFO model.
  task automatic applyStimulus(input logic rstn, input logic f, input logic v,
                               input logic [7:0] c, input logic [DATA_W-1:0] d, input logic r);
    bit inFire;
    bit outFire;
    entry_t e;
    RSTn = rstn;
    flush = f;
    upIf.valid = v;
    upIf.ctrl = c;
    upIf.data = d;
    dnIf.ready = r;
    inFire = v && (modelQ.size() < 2);
    outFire = (modelQ.size() > 0) && r;
    e.ctrl = c;
    e.data = d;
    @(posedge CLK);
    if (!rstn) begin
      modelQ.delete();
      modelStall = '0;
    end else begin
      if ((modelQ.size() > 0) && !r && (modelStall != 32'hFFFF_FFFF)) modelStall = modelStall + 32'd1;
      if (f) begin
        modelQ.delete();
      end else begin
        if (outFire) void'(modelQ.pop_front());
        if (inFire) modelQ.push_back(e);
      end
    end
    #1;
  endtask

  task automatic checkModel(input string tag);
    logic expValid;
    logic [7:0] expCtrl;
    expValid = (modelQ.size() > 0);
    expCtrl = expValid ? modelQ[0].ctrl : 8'h00;
    checkOutput({tag, "_out_valid"}, 128'(dnIf.valid), 128'(expValid));
    checkOutput({tag, "_in_ready"}, 128'(upIf.ready), 128'(modelQ.size() < 2));
    checkOutput({tag, "_out_ctrl"}, 128'(dnIf.ctrl), 128'(expCtrl));
    if (expValid) checkOutput({tag, "_out_data"}, 128'(dnIf.data), 128'(modelQ[0].data));
`ifdef PIPE_STAGE_PERF_EN
    checkOutput({tag, "_stall_cnt"}, 128'(stallCnt), 128'(modelStall));
`endif
  endtask

  task automatic checkStall(input string tag, input logic [31:0] expected);
`ifdef PIPE_STAGE_PERF_EN
    checkOutput(tag, 128'(stallCnt), 128'(expected));
`else
    if (expected == 32'hFFFF_FFFF) $display("[TB] stall counter not built (%s)", tag);
`endif
  endtask

  initial begin
    upIf.valid = 1'b0;
    upIf.ctrl = '0;
    upIf.data = '0;
    dnIf.ready = 1'b1;

    // Reset held for two cycles with a pending upstream entry.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, mkData(8'h55), 1'b1);
      checkOutput("rst_out_valid", 128'(dnIf.valid), 128'(0));
      checkOutput("rst_out_ctrl", 128'(dnIf.ctrl), 128'(0));
      checkOutput("rst_in_ready", 128'(upIf.ready), 128'(1));
    end
    checkStall("rst_stall_cnt", 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h55, mkData(8'h55), 1'b1);
    checkOutput("first_out_valid", 128'(dnIf.valid), 128'(1));
    checkOutput("first_out_ctrl", 128'(dnIf.ctrl), 128'(8'h55));
    checkOutput("first_out_data", 128'(dnIf.data), 128'(mkData(8'h55)));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, mkData(8'h00), 1'b1);
    checkOutput("drain_out_valid", 128'(dnIf.valid), 128'(0));

    // Back-to-back streaming with downstream always ready.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, i[7:0], mkData(i[7:0]), 1'b1);
      checkOutput("stream_out_valid", 128'(dnIf.valid), 128'(1));
      checkOutput("stream_out_ctrl", 128'(dnIf.ctrl), 128'(i[7:0]));
      checkOutput("stream_out_data", 128'(dnIf.data), 128'(mkData(i[7:0])));
      checkOutput("stream_in_ready", 128'(upIf.ready), 128'(1));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, mkData(8'h00), 1'b1);
    checkOutput("stream_end_valid", 128'(dnIf.valid), 128'(0));

    // Backpressure: A, B accepted, C held upstream until release.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA1, mkData(8'hA1), 1'b0);
    checkOutput("bp_a_ctrl", 128'(dnIf.ctrl), 128'(8'hA1));
    checkOutput("bp_a_in_ready", 128'(upIf.ready), 128'(1));
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hB2, mkData(8'hB2), 1'b0);
    checkOutput("bp_b_ctrl", 128'(dnIf.ctrl), 128'(8'hA1));
    checkOutput("bp_b_in_ready", 128'(upIf.ready), 128'(0));
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hC3, mkData(8'hC3), 1'b0);
    checkOutput("bp_c1_ctrl", 128'(dnIf.ctrl), 128'(8'hA1));
    checkOutput("bp_c1_in_ready", 128'(upIf.ready), 128'(0));
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hC3, mkData(8'hC3), 1'b0);
    checkOutput("bp_c2_in_ready", 128'(upIf.ready), 128'(0));
    checkStall("bp_stall_cnt", 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hC3, mkData(8'hC3), 1'b1);
    checkOutput("bp_rel_ctrl_b", 128'(dnIf.ctrl), 128'(8'hB2));
    checkOutput("bp_rel_data_b", 128'(dnIf.data), 128'(mkData(8'hB2)));
    checkOutput("bp_rel_in_ready", 128'(upIf.ready), 128'(1));
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hC3, mkData(8'hC3), 1'b1);
    checkOutput("bp_rel_ctrl_c", 128'(dnIf.ctrl), 128'(8'hC3));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, mkData(8'h00), 1'b1);
    checkOutput("bp_end_valid", 128'(dnIf.valid), 128'(0));
    checkStall("bp_end_stall_cnt", 32'd3);

    // Flush while FULL with a simultaneous upstream 8'hFF.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h11, mkData(8'h11), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h22, mkData(8'h22), 1'b0);
    checkOutput("fl_full_in_ready", 128'(upIf.ready), 128'(0));
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, mkData(8'hFF), 1'b0);
    checkOutput("fl_out_valid", 128'(dnIf.valid), 128'(0));
    checkOutput("fl_out_ctrl", 128'(dnIf.ctrl), 128'(0));
    checkOutput("fl_in_ready", 128'(upIf.ready), 128'(1));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, mkData(8'h00), 1'b1);
    checkOutput("fl_after_valid", 128'(dnIf.valid), 128'(0));
    checkOutput("fl_after_ctrl", 128'(dnIf.ctrl), 128'(0));
    checkStall("fl_stall_cnt", 32'd5);

    // Bubble gating: stale main ctrl 8'h81 must not leak.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h81, mkData(8'h81), 1'b0);
    checkOutput("gate_loaded_ctrl", 128'(dnIf.ctrl), 128'(8'h81));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, mkData(8'h00), 1'b1);
    checkOutput("gate_out_valid", 128'(dnIf.valid), 128'(0));
    checkOutput("gate_out_ctrl", 128'(dnIf.ctrl), 128'(8'h00));
    checkStall("gate_stall_cnt", 32'd5);

    // Randomized traffic against the FIFO scoreboard.
    for (int n = 0; n < 4000; n++) begin
      logic rstn;
      logic f;
      logic v;
      logic r;
      logic [7:0] c;
      logic [DATA_W-1:0] d;
      rstn = ($urandom_range(0, 299) != 0);
      f = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      c = 8'($urandom);
      d = DATA_W'({$urandom, $urandom, $urandom, $urandom});
      applyStimulus(rstn, f, v, c, d, r);
      checkModel("rnd");
    end

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
